// File: rtl/fp_sub16_seq_if.sv
// Operand/result handshake bundle for the multicycle fp16 subtractor.
// master drives operands and consumes results; slave is the subtractor.
interface fp_sub16_seq_if #(
    parameter int W = 16
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         busy;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, result, busy
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, result, busy
    );
endinterface

// File: rtl/fp_sub16_seq.sv
// Multicycle half-precision subtractor (result = a - b), truncating, subnormals flushed.
// Latency: out_valid seen 4 + cnt + k cycles after accept; result held until out_ready.
module fp_sub16_seq #(
    parameter int EXP_W = 5,
    parameter int MAN_W = 10
) (
    input  logic            clk,
    input  logic            reset,
    fp_sub16_seq_if.slave   bus
);
    localparam int W     = 1 + EXP_W + MAN_W;
    localparam int MW    = MAN_W + 2;
    localparam int CNT_W = 4;
    localparam logic [EXP_W-1:0] EXP_MAX = '1;

    typedef enum logic [2:0] {IDLE, ALIGN, ADDSUB, NORM, DONE} state_t;

    state_t              state, state_nx;
    logic                sign_r;
    logic                eff_sub;
    logic [EXP_W-1:0]    exp_r;
    logic [MW-1:0]       big_m;
    logic [MW-1:0]       small_m;
    logic [CNT_W-1:0]    cnt;
    logic                first_norm;
    logic [W-1:0]        res_r;
    logic                out_vld;

    // operand decode; b's sign is flipped so the datapath only ever adds
    logic                a_s, b_s;
    logic [EXP_W-1:0]    a_e, b_e;
    logic [MAN_W-1:0]    a_f, b_f;
    logic [MW-1:0]       a_m, b_m;
    logic                a_big;
    logic [EXP_W-1:0]    exp_diff;
    logic [CNT_W-1:0]    cnt_ld;

    assign a_s      = bus.a[W-1];
    assign b_s      = ~bus.b[W-1];
    assign a_e      = bus.a[W-2 -: EXP_W];
    assign b_e      = bus.b[W-2 -: EXP_W];
    assign a_f      = (a_e == '0) ? '0 : bus.a[MAN_W-1:0];
    assign b_f      = (b_e == '0) ? '0 : bus.b[MAN_W-1:0];
    assign a_m      = {1'b0, (a_e != '0), a_f};
    assign b_m      = {1'b0, (b_e != '0), b_f};
    assign a_big    = {a_e, a_f} >= {b_e, b_f};
    assign exp_diff = a_big ? (a_e - b_e) : (b_e - a_e);
    assign cnt_ld   = (exp_diff > EXP_W'(MAN_W + 1)) ? CNT_W'(MAN_W + 1) : CNT_W'(exp_diff);

    logic                norm_zero, norm_carry, norm_lead, norm_under, norm_next_lead;
    logic [EXP_W:0]      exp_inc;

    assign norm_zero      = (big_m == '0);
    assign norm_carry     = big_m[MW-1];
    assign norm_lead      = big_m[MAN_W];
    assign norm_under     = (exp_r <= EXP_W'(1));
    assign norm_next_lead = big_m[MAN_W-1];
    assign exp_inc        = {1'b0, exp_r} + 1'b1;

    function automatic logic [W-1:0] pack(input logic s, input logic [EXP_W-1:0] e,
                                          input logic [MAN_W-1:0] m);
        if (e == EXP_MAX) return {s, EXP_MAX, {MAN_W{1'b0}}};
        return {s, e, m};
    endfunction

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:   if (bus.in_valid) state_nx = ALIGN;
            ALIGN:  if (cnt == '0) state_nx = ADDSUB;
            ADDSUB: state_nx = NORM;
            // lookahead: the shift that brings the leading 1 into place also finishes
            NORM: begin
                if (first_norm && (norm_zero || norm_carry)) state_nx = DONE;
                else if (norm_lead || norm_under)            state_nx = DONE;
                else if (norm_next_lead)                     state_nx = DONE;
            end
            DONE:   if (bus.out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sign_r     <= 1'b0;
            eff_sub    <= 1'b0;
            exp_r      <= '0;
            big_m      <= '0;
            small_m    <= '0;
            cnt        <= '0;
            first_norm <= 1'b0;
            res_r      <= '0;
            out_vld    <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.in_valid) begin
                    sign_r  <= a_big ? a_s : b_s;
                    eff_sub <= a_s ^ b_s;
                    exp_r   <= a_big ? a_e : b_e;
                    big_m   <= a_big ? a_m : b_m;
                    small_m <= a_big ? b_m : a_m;
                    cnt     <= cnt_ld;
                end
                ALIGN: if (cnt != '0) begin
                    small_m <= small_m >> 1;
                    cnt     <= cnt - 1'b1;
                end
                ADDSUB: begin
                    big_m      <= eff_sub ? (big_m - small_m) : (big_m + small_m);
                    first_norm <= 1'b1;
                end
                NORM: begin
                    first_norm <= 1'b0;
                    if (first_norm && norm_zero) begin
                        res_r   <= '0;
                        out_vld <= 1'b1;
                    end else if (first_norm && norm_carry) begin
                        res_r   <= (exp_inc >= {1'b0, EXP_MAX}) ? {sign_r, EXP_MAX, {MAN_W{1'b0}}}
                                 : {sign_r, exp_inc[EXP_W-1:0], big_m[MAN_W:1]};
                        out_vld <= 1'b1;
                    end else if (norm_lead) begin
                        res_r   <= pack(sign_r, exp_r, big_m[MAN_W-1:0]);
                        out_vld <= 1'b1;
                    end else if (norm_under) begin
                        res_r   <= '0;
                        out_vld <= 1'b1;
                    end else begin
                        big_m <= big_m << 1;
                        exp_r <= exp_r - 1'b1;
                        if (norm_next_lead) begin
                            res_r   <= pack(sign_r, exp_r - 1'b1, {big_m[MAN_W-2:0], 1'b0});
                            out_vld <= 1'b1;
                        end
                    end
                end
                DONE: if (bus.out_ready) out_vld <= 1'b0;
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.busy      = (state != IDLE);
    assign bus.out_valid = out_vld;
    assign bus.result    = res_r;
endmodule
